// File: rtl/otp_shadow_seq.sv
// OTP read/program sequencer: auto-loads DEPTH OTP words into a shadow array and
// programs single words in test mode, reading each one back to verify it.
module otp_shadow_seq #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int T_SETUP  = 2,
    parameter int T_RD     = 4,
    parameter int T_PG     = 200,
    parameter int AUTOLOAD = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              i_run_test_mode,
    input  logic              i_load_req,
    input  logic              i_prog_req,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_load_done,
    output logic              o_prog_err,
    output logic              o_otp_csb,
    output logic              o_otp_strobe,
    output logic              o_otp_load,
    output logic              o_otp_pgenb,
    output logic              o_otp_vddqsw,
    output logic [ADDR_W-1:0] o_otp_addr,
    output logic [DATA_W-1:0] o_otp_d,
    input  logic [DATA_W-1:0] i_otp_q
);

    localparam int T_MAX = (T_PG > T_RD) ? ((T_PG > T_SETUP) ? T_PG : T_SETUP)
                                         : ((T_RD > T_SETUP) ? T_RD : T_SETUP);
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0]  RD_LAST    = CNT_W'(T_RD - 1);
    localparam logic [CNT_W-1:0]  PG_LAST    = CNT_W'(T_PG - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE, RD_SETUP, RD_STROBE, RD_HOLD,
        PG_SETUP, PG_STROBE, PG_HOLD,
        VF_SETUP, VF_STROBE, VF_HOLD
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              autostart_q;
    logic              vf_bad_q;
    logic              load_done_q;
    logic              prog_err_q;
    logic              csb_q, strobe_q, load_q, pgenb_q, vddqsw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] d_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] shadow_q [2**ADDR_W];

    // Single sequencer FSM; every OTP pin is a register updated on state transitions.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            autostart_q <= (AUTOLOAD != 0);
            vf_bad_q    <= 1'b0;
            load_done_q <= 1'b0;
            prog_err_q  <= 1'b0;
            csb_q       <= 1'b1;
            strobe_q    <= 1'b0;
            load_q      <= 1'b0;
            pgenb_q     <= 1'b1;
            vddqsw_q    <= 1'b0;
            addr_q      <= '0;
            d_q         <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) shadow_q[i] <= '0;
        end else begin
            if (state_q != IDLE && i_prog_req) prog_err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // A load start outranks a simultaneous program request, which still flags an error.
                    if (i_load_req || autostart_q) begin
                        autostart_q <= 1'b0;
                        load_done_q <= 1'b0;
                        prog_err_q  <= i_prog_req;
                        cnt_q       <= '0;
                        addr_q      <= '0;
                        csb_q       <= 1'b0;
                        load_q      <= 1'b1;
                        state_q     <= RD_SETUP;
                    end else if (i_prog_req) begin
                        if (i_run_test_mode) begin
                            prog_err_q <= 1'b0;
                            data_q     <= i_prog_data;
                            d_q        <= i_prog_data;
                            addr_q     <= i_prog_addr;
                            cnt_q      <= '0;
                            csb_q      <= 1'b0;
                            pgenb_q    <= 1'b0;
                            vddqsw_q   <= 1'b1;
                            state_q    <= PG_SETUP;
                        end else begin
                            prog_err_q <= 1'b1;
                        end
                    end
                end
                RD_SETUP, VF_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q    <= '0;
                        strobe_q <= 1'b1;
                        state_q  <= (state_q == RD_SETUP) ? RD_STROBE : VF_STROBE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD_STROBE, VF_STROBE: begin
                    if (cnt_q == RD_LAST) begin
                        cnt_q            <= '0;
                        strobe_q         <= 1'b0;
                        shadow_q[addr_q] <= i_otp_q;
                        vf_bad_q         <= (i_otp_q != data_q);
                        state_q          <= (state_q == RD_STROBE) ? RD_HOLD : VF_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (addr_q == LAST_ADDR) begin
                        csb_q       <= 1'b1;
                        load_q      <= 1'b0;
                        load_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        state_q <= RD_SETUP;
                    end
                end
                PG_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q    <= '0;
                        strobe_q <= 1'b1;
                        state_q  <= PG_STROBE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PG_STROBE: begin
                    if (cnt_q == PG_LAST) begin
                        cnt_q    <= '0;
                        strobe_q <= 1'b0;
                        state_q  <= PG_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PG_HOLD: begin
                    // Program enable drops in the same edge read mode rises, so they never overlap.
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q    <= '0;
                        pgenb_q  <= 1'b1;
                        vddqsw_q <= 1'b0;
                        load_q   <= 1'b1;
                        state_q  <= VF_SETUP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                VF_HOLD: begin
                    csb_q   <= 1'b1;
                    load_q  <= 1'b0;
                    state_q <= IDLE;
                    if (vf_bad_q) prog_err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= shadow_q[i_rd_addr];
    end

    assign o_rd_data    = rd_data_q;
    assign o_busy       = (state_q != IDLE);
    assign o_load_done  = load_done_q;
    assign o_prog_err   = prog_err_q;
    assign o_otp_csb    = csb_q;
    assign o_otp_strobe = strobe_q;
    assign o_otp_load   = load_q;
    assign o_otp_pgenb  = pgenb_q;
    assign o_otp_vddqsw = vddqsw_q;
    assign o_otp_addr   = addr_q;
    assign o_otp_d      = d_q;

endmodule

// File: tb/tb_otp_shadow_seq.sv
// Directed bench for otp_shadow_seq with a behavioural OTP macro whose unprogrammed
// word k reads k^8'hA5 and whose programmed words can have bits stuck at 0.
module tb_otp_shadow_seq;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_run_test_mode = 1'b0;
    logic       i_load_req = 1'b0;
    logic       i_prog_req = 1'b0;
    logic [4:0] i_prog_addr = '0;
    logic [7:0] i_prog_data = '0;
    logic [4:0] i_rd_addr = '0;
    logic [7:0] o_rd_data;
    logic       o_busy, o_load_done, o_prog_err;
    logic       o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb, o_otp_vddqsw;
    logic [4:0] o_otp_addr;
    logic [7:0] o_otp_d;
    logic [7:0] i_otp_q;

    int checks = 0;
    int failures = 0;

    logic [7:0]  stuckMask = 8'hFF;
    logic [7:0]  progVal [32];
    logic [31:0] progValid = '0;

    int overlapCount = 0;
    int pgenbLowCount = 0;
    int csbLowCount = 0;
    int pgRun = 0;
    int pgLen = 0;

    otp_shadow_seq dut (
        .sys_clk(sys_clk), .rst(rst), .i_run_test_mode(i_run_test_mode),
        .i_load_req(i_load_req), .i_prog_req(i_prog_req),
        .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy),
        .o_load_done(o_load_done), .o_prog_err(o_prog_err),
        .o_otp_csb(o_otp_csb), .o_otp_strobe(o_otp_strobe), .o_otp_load(o_otp_load),
        .o_otp_pgenb(o_otp_pgenb), .o_otp_vddqsw(o_otp_vddqsw),
        .o_otp_addr(o_otp_addr), .o_otp_d(o_otp_d), .i_otp_q(i_otp_q)
    );

    always #5 sys_clk = ~sys_clk;

    // OTP macro model: a program strobe stores d with the stuck-bit mask applied.
    assign i_otp_q = progValid[o_otp_addr] ? progVal[o_otp_addr] : ({3'b000, o_otp_addr} ^ 8'hA5);

    always @(posedge sys_clk) begin
        if (o_otp_strobe && !o_otp_pgenb) begin
            progVal[o_otp_addr]   <= o_otp_d & stuckMask;
            progValid[o_otp_addr] <= 1'b1;
        end
    end

    // Pin monitor: counts illegal overlaps and measures program strobe length.
    always @(negedge sys_clk) begin
        if (!o_otp_pgenb && o_otp_load) overlapCount++;
        if (!o_otp_pgenb) pgenbLowCount++;
        if (!o_otp_csb) csbLowCount++;
        if (o_otp_strobe && !o_otp_pgenb) pgRun++;
        else if (pgRun != 0) begin
            pgLen = pgRun;
            pgRun = 0;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({o_otp_csb, o_otp_pgenb, o_otp_strobe, o_otp_load, o_otp_vddqsw} !== 5'b11000) begin
            failures++;
            $display("[TB] FAIL reset_pins: got %b expected 11000",
                     {o_otp_csb, o_otp_pgenb, o_otp_strobe, o_otp_load, o_otp_vddqsw});
        end
        checks++;
        if ({o_otp_addr, o_otp_d} !== 13'h0) begin
            failures++;
            $display("[TB] FAIL reset_addr_d: got %h/%h expected 00/00", o_otp_addr, o_otp_d);
        end
        checks++;
        if ({o_busy, o_load_done, o_prog_err} !== 3'b000 || o_rd_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_status: got %b rd=%h expected 000 rd=00",
                     {o_busy, o_load_done, o_prog_err}, o_rd_data);
        end
    endtask

    task automatic test_autoload();
        int n = 0;
        int pgSnap = pgenbLowCount;
        rst = 1'b0;
        while (n < 400) begin
            tick();
            n++;
            if (n == 1) begin
                checks++;
                if (!(o_busy === 1'b1 && o_otp_csb === 1'b0 && o_otp_load === 1'b1 && o_otp_addr === 5'd0)) begin
                    failures++;
                    $display("[TB] FAIL autoload_start: got busy=%b csb=%b load=%b addr=%0d expected 1 0 1 0",
                             o_busy, o_otp_csb, o_otp_load, o_otp_addr);
                end
            end
            if (o_load_done) break;
        end
        checks++;
        if (n !== 225) begin
            failures++;
            $display("[TB] FAIL autoload_cycles: got %0d expected 225", n);
        end
        checks++;
        if (pgenbLowCount !== pgSnap) begin
            failures++;
            $display("[TB] FAIL autoload_pgenb: got %0d low cycles expected 0", pgenbLowCount - pgSnap);
        end
        i_rd_addr = 5'd3;
        tick();
        checks++;
        if (o_rd_data !== 8'hA6) begin
            failures++;
            $display("[TB] FAIL autoload_rd3: got %h expected a6", o_rd_data);
        end
        i_rd_addr = 5'd31;
        tick();
        checks++;
        if (o_rd_data !== 8'hBA) begin
            failures++;
            $display("[TB] FAIL autoload_rd31: got %h expected ba", o_rd_data);
        end
    endtask

    task automatic test_program(input logic [4:0] a, input logic [7:0] dat, input logic [7:0] mask,
                                input logic [7:0] expShadow, input logic expErr, input string name);
        int n = 0;
        stuckMask = mask;
        i_run_test_mode = 1'b1;
        i_prog_addr = a;
        i_prog_data = dat;
        i_prog_req = 1'b1;
        tick();
        i_prog_req = 1'b0;
        checks++;
        if (!(o_busy === 1'b1 && o_otp_pgenb === 1'b0 && o_otp_vddqsw === 1'b1 &&
              o_otp_csb === 1'b0 && o_otp_addr === a && o_otp_d === dat)) begin
            failures++;
            $display("[TB] FAIL %s_setup: got busy=%b pgenb=%b vddqsw=%b addr=%0d d=%h expected 1 0 1 %0d %h",
                     name, o_busy, o_otp_pgenb, o_otp_vddqsw, o_otp_addr, o_otp_d, a, dat);
        end
        while (o_busy && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 211) begin
            failures++;
            $display("[TB] FAIL %s_cycles: got %0d expected 211", name, n);
        end
        checks++;
        if (pgLen !== 200) begin
            failures++;
            $display("[TB] FAIL %s_strobe_len: got %0d expected 200", name, pgLen);
        end
        checks++;
        if (o_prog_err !== expErr || {o_otp_csb, o_otp_pgenb, o_otp_vddqsw, o_otp_load} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL %s_end: got err=%b pins=%b expected err=%b pins=1100",
                     name, o_prog_err, {o_otp_csb, o_otp_pgenb, o_otp_vddqsw, o_otp_load}, expErr);
        end
        i_rd_addr = a;
        tick();
        checks++;
        if (o_rd_data !== expShadow) begin
            failures++;
            $display("[TB] FAIL %s_shadow: got %h expected %h", name, o_rd_data, expShadow);
        end
        stuckMask = 8'hFF;
    endtask

    task automatic test_rejected();
        int n = 0;
        int csbSnap;
        int pgSnap;
        i_run_test_mode = 1'b0;
        i_prog_addr = 5'd2;
        i_prog_data = 8'h55;
        i_prog_req = 1'b1;
        tick();
        i_prog_req = 1'b0;
        csbSnap = csbLowCount;
        repeat (5) tick();
        checks++;
        if (csbLowCount !== csbSnap || o_busy !== 1'b0 || o_prog_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rej_testmode: got csb_low=%0d busy=%b err=%b expected 0 0 1",
                     csbLowCount - csbSnap, o_busy, o_prog_err);
        end
        pgSnap = pgenbLowCount;
        i_load_req = 1'b1;
        tick();
        i_load_req = 1'b0;
        checks++;
        if ({o_busy, o_load_done, o_prog_err} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL rej_load_start: got %b expected 100", {o_busy, o_load_done, o_prog_err});
        end
        while (n < 400) begin
            tick();
            n++;
            if (o_load_done) break;
            if (n == 51) begin
                checks++;
                if (o_prog_err !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL rej_busy_err: got %b expected 1", o_prog_err);
                end
            end
            i_run_test_mode = 1'b1;
            i_prog_req = (n == 50);
            i_load_req = (n == 60);
        end
        i_prog_req = 1'b0;
        i_load_req = 1'b0;
        checks++;
        if (n !== 224 || o_prog_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rej_load_cycles: got %0d err=%b expected 224 err=1", n, o_prog_err);
        end
        checks++;
        if (pgenbLowCount !== pgSnap) begin
            failures++;
            $display("[TB] FAIL rej_pgenb: got %0d low cycles expected 0", pgenbLowCount - pgSnap);
        end
        i_rd_addr = 5'd5;
        tick();
        checks++;
        if (o_rd_data !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL rej_rd5: got %h expected 3c", o_rd_data);
        end
        i_rd_addr = 5'd4;
        tick();
        checks++;
        if (o_rd_data !== 8'hA1) begin
            failures++;
            $display("[TB] FAIL rej_rd4: got %h expected a1", o_rd_data);
        end
    endtask

    task automatic test_reset_mid_load();
        int n = 0;
        bit found = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        while (n < 300) begin
            tick();
            n++;
            if (o_otp_addr == 5'd10 && o_otp_strobe) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL midrst_reach: got no strobe at word 10 expected one within 300 cycles");
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({o_otp_csb, o_otp_pgenb, o_otp_strobe, o_otp_load, o_otp_vddqsw} !== 5'b11000 ||
            o_otp_addr !== 5'd0 || o_otp_d !== 8'h00 || {o_busy, o_load_done, o_prog_err} !== 3'b000 ||
            o_rd_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midrst_values: got pins=%b addr=%0d d=%h st=%b rd=%h expected 11000 0 00 000 00",
                     {o_otp_csb, o_otp_pgenb, o_otp_strobe, o_otp_load, o_otp_vddqsw},
                     o_otp_addr, o_otp_d, {o_busy, o_load_done, o_prog_err}, o_rd_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (!(o_busy === 1'b1 && o_otp_addr === 5'd0 && o_otp_load === 1'b1 && o_otp_csb === 1'b0 &&
              o_rd_data === 8'h00)) begin
            failures++;
            $display("[TB] FAIL midrst_restart: got busy=%b addr=%0d load=%b csb=%b rd=%h expected 1 0 1 0 00",
                     o_busy, o_otp_addr, o_otp_load, o_otp_csb, o_rd_data);
        end
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (o_load_done) break;
        end
        checks++;
        if (n !== 224) begin
            failures++;
            $display("[TB] FAIL midrst_cycles: got %0d expected 224", n);
        end
    endtask

    task automatic test_load_prog_same();
        int n = 0;
        int pgSnap = pgenbLowCount;
        i_run_test_mode = 1'b1;
        i_prog_addr = 5'd9;
        i_prog_data = 8'h00;
        i_load_req = 1'b1;
        i_prog_req = 1'b1;
        tick();
        i_load_req = 1'b0;
        i_prog_req = 1'b0;
        checks++;
        if (!(o_prog_err === 1'b1 && o_busy === 1'b1 && o_otp_load === 1'b1 && o_otp_pgenb === 1'b1)) begin
            failures++;
            $display("[TB] FAIL same_start: got err=%b busy=%b load=%b pgenb=%b expected 1 1 1 1",
                     o_prog_err, o_busy, o_otp_load, o_otp_pgenb);
        end
        while (n < 400) begin
            tick();
            n++;
            if (o_load_done) break;
        end
        checks++;
        if (n !== 224 || o_prog_err !== 1'b1 || pgenbLowCount !== pgSnap) begin
            failures++;
            $display("[TB] FAIL same_end: got cycles=%0d err=%b pgenb_low=%0d expected 224 1 0",
                     n, o_prog_err, pgenbLowCount - pgSnap);
        end
        i_rd_addr = 5'd9;
        tick();
        checks++;
        if (o_rd_data !== 8'hAC) begin
            failures++;
            $display("[TB] FAIL same_rd9: got %h expected ac", o_rd_data);
        end
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_autoload();
        test_program(5'd5, 8'h3C, 8'hFF, 8'h3C, 1'b0, "prog_ok");
        test_program(5'd5, 8'h3D, 8'hFE, 8'h3C, 1'b1, "prog_stuck");
        test_program(5'd7, 8'h81, 8'hFF, 8'h81, 1'b0, "prog_clear");
        test_rejected();
        test_reset_mid_load();
        test_load_prog_same();
        checks++;
        if (overlapCount !== 0) begin
            failures++;
            $display("[TB] FAIL pgenb_load_overlap: got %0d cycles expected 0", overlapCount);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
